fetch_queue: RTL

- Instruction fetch buffer between the fetch stage (PC register, instruction memory, branch predictor) and the IF/ID pipeline register.
- Holds up to DEPTH fetched instructions, each with its PC and branch-prediction metadata.
- Absorbs decode stalls so fetch can run ahead.
- Is flushed when EX resolves a mispredict.

---
 rtl/fetch_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch buffer between the fetch stage and the IF/ID register.
//   It holds up to DEPTH fetched instructions, each with its PC and the branch
//   predictor metadata captured at fetch time. This lets fetch run ahead while
//   decode is stalled. A mispredict flush from EX empties the queue.
//
// Parameters
//   DEPTH : number of entries (power of two, >= 2)
//   XLEN  : PC / instruction width
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset (0 = reset)
//   flush          in   discard all entries at the next edge
//   enq_valid      in   fetch presents an instruction
//   enq_ready      out  queue can accept (cnt != DEPTH, state only)
//   enq_pc         in   PC of fetched instruction
//   enq_instr      in   fetched instruction word
//   enq_bp_state   in   2-bit predictor counter state at fetch
//   enq_pred_taken in   predictor taken decision at fetch
//   deq_valid      out  head entry valid toward IF/ID
//   deq_ready      in   decode accepts head (0 = hazard stall)
//   deq_pc         out  head PC (0 when deq_valid = 0)
//   deq_instr      out  head instruction (0 when deq_valid = 0)
//   deq_bp_state   out  head predictor state (0 when deq_valid = 0)
//   deq_pred_taken out  head prediction (0 when deq_valid = 0)
//   count          out  current occupancy
//
// Build option
//   FETCH_QUEUE_BYPASS_EN : when defined, an empty queue passes an incoming
//   instruction straight to deq_* in the same cycle if decode is ready. The
//   entry is consumed without being written. When undefined, the minimum
//   latency through the queue is one cycle.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_instr,
  input  logic [1:0]               enq_bp_state,
  input  logic                     enq_pred_taken,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_instr,
  output logic [1:0]               deq_bp_state,
  output logic                     deq_pred_taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage and control state
  logic [XLEN-1:0]  mem_pc_q    [DEPTH];
  logic [XLEN-1:0]  mem_instr_q [DEPTH];
  logic [1:0]       mem_bp_q    [DEPTH];
  logic             mem_pt_q    [DEPTH];
  logic [XLEN-1:0]  mem_pc_d    [DEPTH];
  logic [XLEN-1:0]  mem_instr_d [DEPTH];
  logic [1:0]       mem_bp_d    [DEPTH];
  logic             mem_pt_d    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             empty;
  logic             full;
  logic             byp;
  logic             enq_fire;
  logic             deq_fire;

  // Handshake decode
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == FULL_CNT);
    byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Zero-latency passthrough: the entry goes straight to decode and never
    // touches storage, so pointers and cnt stay put.
    byp   = empty & enq_valid & deq_ready & ~flush;
`else
    byp   = 1'b0;
`endif
    enq_ready = ~full;
    deq_valid = ~empty | byp;
    // Writes and storage-side reads exclude the bypass case; a full queue
    // refuses a write even if the head leaves in the same cycle.
    enq_fire  = enq_valid & ~full & ~byp & ~flush;
    deq_fire  = deq_ready & ~empty & ~flush;
  end

  // Head presentation; payload is forced to zero whenever nothing is valid
  always_comb begin
    deq_pc         = '0;
    deq_instr      = '0;
    deq_bp_state   = '0;
    deq_pred_taken = 1'b0;
    if (!empty) begin
      deq_pc         = mem_pc_q[rd_ptr_q];
      deq_instr      = mem_instr_q[rd_ptr_q];
      deq_bp_state   = mem_bp_q[rd_ptr_q];
      deq_pred_taken = mem_pt_q[rd_ptr_q];
    end else if (byp) begin
      deq_pc         = enq_pc;
      deq_instr      = enq_instr;
      deq_bp_state   = enq_bp_state;
      deq_pred_taken = enq_pred_taken;
    end
  end

  assign count = cnt_q;

  // Next-state: pointers, occupancy and storage
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    mem_bp_d    = mem_bp_q;
    mem_pt_d    = mem_pt_q;

    if (flush) begin
      // Storage contents are left alone; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_fire) begin
        mem_pc_d[wr_ptr_q]    = enq_pc;
        mem_instr_d[wr_ptr_q] = enq_instr;
        mem_bp_d[wr_ptr_q]    = enq_bp_state;
        mem_pt_d[wr_ptr_q]    = enq_pred_taken;
        // DEPTH is a power of two, so the natural wrap of PTR_W bits is exact.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
        mem_bp_q[i]    <= '0;
        mem_pt_q[i]    <= 1'b0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
      mem_bp_q    <= mem_bp_d;
      mem_pt_q    <= mem_pt_d;
    end
  end

endmodule
